// File: rtl/stack_ram_ctrl.sv
// LIFO stack controller over a downward-growing register-file RAM.
// Pops return data one cycle later; simultaneous push+pop swaps the top entry.
module stack_ram_ctrl #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_vld,
    output logic [DEPTH_LOG2-1:0] sp,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf,
    output logic                  unf
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RD   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] sp_q,    sp_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [WIDTH-1:0]      dout_q,  dout_d;
    logic                  ovf_q,   ovf_d;
    logic                  unf_q,   unf_d;
    logic                  ovf_set, unf_set;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      rd_data;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == CW'(0));
    assign sp       = sp_q;
    assign count    = cnt_q;
    assign dout     = dout_q;
    assign dout_vld = (state_q == ST_RD);
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    // Read port sees the pre-edge contents, giving read-before-write on swap.
    assign rd_data = mem_q[sp_q];

    // Next-state: FSM, pointer/count, output data, error flags, RAM write.
    always_comb begin
        state_d   = ST_IDLE;
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = sp_q;
        mem_wdata = din;

        if (push && pop && !empty) begin
            mem_we  = 1'b1;
            dout_d  = rd_data;
            state_d = ST_RD;
        end else if (push && !full) begin
            mem_we    = 1'b1;
            mem_waddr = sp_q - DEPTH_LOG2'(1);
            sp_d      = sp_q - DEPTH_LOG2'(1);
            cnt_d     = cnt_q + CW'(1);
        end else if (push) begin
            ovf_set = 1'b1;
        end else if (pop && !empty) begin
            dout_d  = rd_data;
            sp_d    = sp_q + DEPTH_LOG2'(1);
            cnt_d   = cnt_q - CW'(1);
            state_d = ST_RD;
        end else if (pop) begin
            unf_set = 1'b1;
        end

        // A new error in the clearing cycle wins over the clear.
        ovf_d = (ovf_q && !clr_err) || ovf_set;
        unf_d = (unf_q && !clr_err) || unf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sp_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_stack_ram_ctrl.sv
// Directed + randomized bench for stack_ram_ctrl against a queue-based LIFO model.
module tb_stack_ram_ctrl;

    localparam int unsigned W  = 10;
    localparam int unsigned DL = 8;
    localparam int unsigned N  = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, pop, clr_err;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic [DL-1:0] sp;
    logic [DL:0]   count;
    logic          full, empty, ovf, unf;

    stack_ram_ctrl #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .clr_err(clr_err), .dout(dout), .dout_vld(dout_vld), .sp(sp),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int      n_vec = 0;
    int      n_err = 0;
    int      q[$];
    int      m_dout = 0;
    bit      m_vld = 0, m_ovf = 0, m_unf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int c = q.size();
        check({tag, ":count"}, 32'(count), 32'(c));
        check({tag, ":sp"},    32'(sp), 32'((N - c) % N));
        check({tag, ":empty"}, 32'(empty), 32'(c == 0));
        check({tag, ":full"},  32'(full), 32'(c == N));
        check({tag, ":vld"},   32'(dout_vld), 32'(m_vld));
        check({tag, ":dout"},  32'(dout), 32'(m_dout));
        check({tag, ":ovf"},   32'(ovf), 32'(m_ovf));
        check({tag, ":unf"},   32'(unf), 32'(m_unf));
    endtask

    // One clock: apply inputs, advance the LIFO model, check just after the edge.
    task automatic step(input string tag, input bit p, input bit o, input int d, input bit c);
        bit set_o = 0, set_u = 0;
        push = p; pop = o; din = W'(d); clr_err = c;
        m_vld = 0;
        if (p && o && q.size() != 0) begin
            m_dout = q[$];
            q[$] = d & ((1 << W) - 1);
            m_vld = 1;
        end else if (p) begin
            if (q.size() < N) q.push_back(d & ((1 << W) - 1));
            else set_o = 1;
        end else if (o) begin
            if (q.size() != 0) begin
                m_dout = q.pop_back();
                m_vld = 1;
            end else set_u = 1;
        end
        m_ovf = (m_ovf && !c) || set_o;
        m_unf = (m_unf && !c) || set_u;
        @(posedge clk);
        #1;
        check_all(tag);
        push = 0; pop = 0; clr_err = 0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0; push = 0; pop = 0; clr_err = 0; din = '0;
        q.delete();
        m_dout = 0; m_vld = 0; m_ovf = 0; m_unf = 0;
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int v;
        bit p, o, c;
        rst_n = 0; push = 0; pop = 0; clr_err = 0; din = '0;
        do_reset("reset0");

        // Basic LIFO with two entries
        step("push155", 1, 0, 'h155, 0);
        step("push0aa", 1, 0, 'h0aa, 0);
        step("pop1",    0, 1, 0, 0);
        step("pop2",    0, 1, 0, 0);
        step("idle1",   0, 0, 0, 0);

        // Underflow then clear
        step("unf",     0, 1, 0, 0);
        step("unf_hold",0, 0, 0, 0);
        step("unf_clr", 0, 0, 0, 1);

        // Swap on non-empty stack
        step("push011", 1, 0, 'h011, 0);
        step("swap",    1, 1, 'h022, 0);
        step("pop022",  0, 1, 0, 0);
        step("idle2",   0, 0, 0, 0);

        // Push+pop on empty acts as push
        step("pp_empty",1, 1, 'h3ff, 0);
        step("pop3ff",  0, 1, 0, 0);
        step("idle3",   0, 0, 0, 0);

        // Fill, overflow, swap when full, sticky vs clear, drain
        for (int i = 0; i < int'(N); i++) step("fill", 1, 0, (i * 7 + 3) & 'h3ff, 0);
        step("ovf",       1, 0, 'h123, 0);
        step("ovf_clr",   0, 0, 0, 1);
        step("swap_full", 1, 1, 'h2bc, 0);
        step("ovf_clr_n", 1, 0, 'h111, 1);
        step("ovf_clr2",  0, 0, 0, 1);
        for (int i = 0; i < int'(N); i++) step("drain", 0, 1, 0, 0);
        step("unf_clr_n", 0, 1, 0, 1);
        step("idle4",     0, 0, 0, 1);

        // Reset while a pop result is being presented
        step("push_r",  1, 0, 'h0f0, 0);
        step("pop_r",   0, 1, 0, 0);
        #2;
        do_reset("reset_rd");
        step("post_rst", 0, 0, 0, 0);
        step("first_push", 1, 0, 'h2a5, 0);
        step("pop_fp",  0, 1, 0, 0);

        // Randomized traffic with alternating push-heavy / pop-heavy phases
        for (int i = 0; i < 2400; i++) begin
            v = int'($urandom_range(0, 99));
            if ((i / 300) % 2 == 0) begin
                p = (v < 75); o = (v >= 60);
            end else begin
                p = (v < 25); o = (v >= 10);
            end
            c = ($urandom_range(0, 15) == 0);
            step("rand", p, o, int'($urandom_range(0, 1023)), c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_ram_ctrl.md
STACK_RAM_CTRL -- requirements
Module: stack_ram_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, giving 2**DEPTH_LOG2 entries (256 by default).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port push  input  1  write din onto the stack this cycle.
REQ-006 Port pop  input  1  remove the top entry this cycle.
REQ-007 Port din  input  WIDTH  push data.
REQ-008 Port clr_err  input  1  synchronous clear of the sticky error flags.
REQ-009 Port dout  output  WIDTH  popped data, valid when dout_vld=1.
REQ-010 Port dout_vld  output  1  one-cycle pulse marking dout valid.
REQ-011 Port sp  output  DEPTH_LOG2  current stack pointer, i.e. the address of the top entry.
REQ-012 Port count  output  DEPTH_LOG2+1  number of stored entries.
REQ-013 Ports full and empty  output  1 each  count==2**DEPTH_LOG2 and count==0, combinational from count.
REQ-014 Ports ovf and unf  output  1 each  sticky overflow and underflow error flags.

Function
REQ-015 The stack SHALL grow downward, matching the CPU stack convention: sp starts at 0, the first push writes address 0xFF, and the second push writes 0xFE.
REQ-016 A push alone, when not full, SHALL take effect on one clock edge: sp<=sp-1 (mod 2**DEPTH_LOG2), mem[sp-1]<=din, count+1.
REQ-017 A pop alone, when not empty, SHALL read mem[sp] and then set sp<=sp+1 (mod 2**DEPTH_LOG2) and count-1.
REQ-018 Pop latency SHALL be 1 cycle: for a pop accepted at edge N, dout holds the data and dout_vld=1 for exactly the cycle after edge N.
REQ-019 dout SHALL hold its last value when dout_vld=0.
REQ-020 The controller SHALL be an FSM with two states: IDLE and RD.
  - An accepted pop moves IDLE->RD.
  - RD->IDLE occurs unless another pop is accepted in the same cycle, in which case the FSM stays in RD.
  - dout_vld=1 exactly when the FSM is in RD.
REQ-021 Back-to-back pops SHALL be accepted every cycle, giving a continuous dout_vld stream in LIFO order.
REQ-022 Push and pop asserted together, when not empty, SHALL perform a swap:
  - dout_vld and dout return the old mem[sp] next cycle.
  - mem[sp]<=din.
  - sp and count are unchanged.
  - The memory SHALL use read-before-write behaviour for this case.
REQ-023 Push and pop asserted together when empty SHALL act as push only, with no dout_vld and no unf.
REQ-024 A push when full (without pop) SHALL be ignored and SHALL set ovf; memory, sp and count are unchanged.
REQ-025 A pop when empty (without push) SHALL be ignored and SHALL set unf; no dout_vld is produced.
REQ-026 Push and pop asserted together when full SHALL perform the swap of REQ-022, with no ovf.
REQ-027 ovf and unf SHALL remain set until clr_err=1 at a clock edge or reset. If a new error occurs in the same cycle as clr_err, the flag SHALL stay set.
REQ-028 Pointer wrap SHALL be modular: with count tracking occupancy, sp=0 with count=256 is full and sp=0 with count=0 is empty.
REQ-029 Memory contents SHALL NOT be reset and are undefined until written.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force:
  - sp=0, count=0, empty=1, full=0
  - ovf=0, unf=0
  - dout_vld=0, dout=0
  - FSM=IDLE
REQ-031 Reset asserted while a pop is in RD SHALL abort it; no dout_vld SHALL appear after reset release.
REQ-032 The first clock edge after rst_n rises SHALL accept push and pop normally.

Verification
REQ-033 Push 0x155 then 0x0AA, then pop twice -> sp goes 0xFF, 0xFE, 0xFF, 0x00; dout=0x0AA then 0x155 on consecutive dout_vld cycles; empty=1 at end.
REQ-034 Push 256 distinct values -> full=1, sp=0x00; a 257th push -> ovf=1 with sp and count unchanged; popping 256 times returns the values in reverse order.
REQ-035 Pop on an empty stack -> unf=1, no dout_vld; then clr_err pulse -> unf=0.
REQ-036 With 0x011 on top, push and pop together with din=0x022 -> next-cycle dout=0x011, count unchanged; a following pop returns 0x022.
REQ-037 Drive rst_n low in the cycle after a pop is accepted -> dout_vld=0 immediately, sp=0, count=0.
REQ-038 Push and pop together on an empty stack with din=0x3FF -> count=1, sp=0xFF, no dout_vld, unf=0.
